// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA timing generator: lock synchronizer, h/v counters and
// registered timing decode, all outputs aligned one cycle behind the counters.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Both totals must fit in the 10-bit counters (<= 1024).
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    logic       lock_meta;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_vis;
    logic       v_vis;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync_on;
    logic       v_sync_on;

    assign h_vis     = (h_cnt < H_VIS);
    assign v_vis     = (v_cnt < V_VIS);
    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign h_sync_on = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign v_sync_on = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

    // pll_locked is asynchronous to clk, so it needs two flops before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            running   <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            running   <= lock_meta;
        end
    end

    // Losing lock parks everything at h=v=0 so the next frame starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!running) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
            hsync       <= h_sync_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_sync_on ? SYNC_POL : ~SYNC_POL;
            de          <= h_vis && v_vis;
            pix_x       <= (h_vis && v_vis) ? h_cnt : 10'd0;
            pix_y       <= (h_vis && v_vis) ? v_cnt : 10'd0;
            line_start  <= (h_cnt == 10'd0);
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a scaled-down instance (32x19 totals) for
// frame-level behaviour plus a default-parameter instance for one full 800-clock line.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst;
    logic       pll_locked;

    logic       hsync, vsync, de, line_start, frame_start, running;
    logic [9:0] pix_x, pix_y;

    logic       d_hsync, d_vsync, d_de, d_line_start, d_frame_start, d_running;
    logic [9:0] d_pix_x, d_pix_y;

    int checks = 0;
    int errors = 0;

    // Scaled timing: H 16+4+8+4=32, V 12+2+2+3=19, frame = 608 clocks.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .de(de),
        .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    vga_timing_gen dut_default (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
        .pix_x(d_pix_x), .pix_y(d_pix_y),
        .line_start(d_line_start), .frame_start(d_frame_start), .running(d_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [25:0] out_vec;
    assign out_vec = {running, hsync, vsync, de, pix_x, pix_y, line_start, frame_start};
    localparam logic [25:0] IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    localparam logic [25:0] IDLE_RUN = {1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_vec !== IDLE) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", out_vec, IDLE);
        end
        checks++;
        if ({d_running, d_hsync, d_vsync, d_de} !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL reset_default: got %b expected 0110",
                     {d_running, d_hsync, d_vsync, d_de});
        end
    endtask

    // Called at a negedge with rst high and pll_locked high.
    task automatic test_startup();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vec !== IDLE) begin
            errors++;
            $display("[TB] FAIL startup_edge1: got %h expected %h", out_vec, IDLE);
        end
        @(negedge clk);
        checks++;
        if (out_vec !== IDLE_RUN) begin
            errors++;
            $display("[TB] FAIL startup_edge2: got %h expected %h", out_vec, IDLE_RUN);
        end
        @(negedge clk);
        checks++;
        if ({de, pix_x, pix_y, line_start, frame_start} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL startup_first_pixel: got de=%b x=%0d y=%0d ls=%b fs=%b expected 1 0 0 1 1",
                     de, pix_x, pix_y, line_start, frame_start);
        end
    endtask

    // Entered at the negedge showing h=0, v=0.
    task automatic test_line();
        int de_cnt   = 0;
        int hs_cnt   = 0;
        int hs_first = -1;
        int ls_cnt   = 0;
        for (int i = 0; i < 32; i++) begin
            if (de) de_cnt++;
            if (!hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (line_start) ls_cnt++;
            if (i == 15) begin
                checks++;
                if (pix_x !== 10'd15 || de !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL line_last_x: got x=%0d de=%b expected 15 1", pix_x, de);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (de_cnt != 16) begin
            errors++;
            $display("[TB] FAIL line_de_count: got %0d expected 16", de_cnt);
        end
        checks++;
        if (hs_cnt != 8 || hs_first != 20) begin
            errors++;
            $display("[TB] FAIL line_hsync: got width=%0d start=%0d expected 8 20", hs_cnt, hs_first);
        end
        checks++;
        if (ls_cnt != 1 || line_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL line_period: got count=%0d ls_now=%b expected 1 1", ls_cnt, line_start);
        end
        checks++;
        if ({de, pix_x, pix_y, frame_start} !== {1'b1, 10'd0, 10'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL line2_start: got de=%b x=%0d y=%0d fs=%b expected 1 0 1 0",
                     de, pix_x, pix_y, frame_start);
        end
    endtask

    task automatic test_frame();
        int n        = 0;
        int de_cnt   = 0;
        int de_lines = 0;
        int vs_cnt   = 0;
        int vs_first = -1;
        int ls_cnt   = 0;
        int fs_cnt   = 0;
        while (frame_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("[TB] FAIL frame_wait: got timeout expected frame_start");
        end
        for (int i = 0; i < 608; i++) begin
            if (de) de_cnt++;
            if (de && line_start) de_lines++;
            if (!vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            @(negedge clk);
        end
        checks++;
        if (de_cnt != 192 || de_lines != 12) begin
            errors++;
            $display("[TB] FAIL frame_de: got cycles=%0d lines=%0d expected 192 12", de_cnt, de_lines);
        end
        checks++;
        if (vs_cnt != 64 || vs_first != 448) begin
            errors++;
            $display("[TB] FAIL frame_vsync: got width=%0d start=%0d expected 64 448", vs_cnt, vs_first);
        end
        checks++;
        if (ls_cnt != 19 || fs_cnt != 1 || frame_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_period: got lines=%0d fs=%0d fs_now=%b expected 19 1 1",
                     ls_cnt, fs_cnt, frame_start);
        end
    endtask

    // Entered at frame index 0; last visible pixel is index 11*32+15 = 367.
    task automatic test_last_pixel();
        repeat (367) @(negedge clk);
        checks++;
        if ({de, pix_x, pix_y} !== {1'b1, 10'd15, 10'd11}) begin
            errors++;
            $display("[TB] FAIL last_pixel: got de=%b x=%0d y=%0d expected 1 15 11", de, pix_x, pix_y);
        end
        @(negedge clk);
        checks++;
        if ({de, pix_x, pix_y} !== {1'b0, 10'd0, 10'd0}) begin
            errors++;
            $display("[TB] FAIL after_last_pixel: got de=%b x=%0d y=%0d expected 0 0 0", de, pix_x, pix_y);
        end
    endtask

    task automatic test_lock_loss();
        int n = 0;
        while (frame_start !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("[TB] FAIL lock_wait: got timeout expected frame_start");
        end
        repeat (170) @(negedge clk);
        checks++;
        if ({de, pix_x, pix_y} !== {1'b1, 10'd10, 10'd5}) begin
            errors++;
            $display("[TB] FAIL lock_midframe: got de=%b x=%0d y=%0d expected 1 10 5", de, pix_x, pix_y);
        end
        pll_locked = 1'b0;
        @(negedge clk);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_drop_edge1: got running=%b expected 1", running);
        end
        @(negedge clk);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_drop_edge2: got running=%b expected 0", running);
        end
        @(negedge clk);
        checks++;
        if (out_vec !== IDLE) begin
            errors++;
            $display("[TB] FAIL lock_drop_idle: got %h expected %h", out_vec, IDLE);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (out_vec !== IDLE) begin
            errors++;
            $display("[TB] FAIL lock_hold_idle: got %h expected %h", out_vec, IDLE);
        end
        pll_locked = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vec !== IDLE) begin
            errors++;
            $display("[TB] FAIL relock_edge1: got %h expected %h", out_vec, IDLE);
        end
        @(negedge clk);
        checks++;
        if (out_vec !== IDLE_RUN) begin
            errors++;
            $display("[TB] FAIL relock_edge2: got %h expected %h", out_vec, IDLE_RUN);
        end
        @(negedge clk);
        checks++;
        if ({de, pix_x, pix_y, frame_start} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL relock_first_pixel: got de=%b x=%0d y=%0d fs=%b expected 1 0 0 1",
                     de, pix_x, pix_y, frame_start);
        end
    endtask

    // Entered at frame index 0; index 20 is h=20, the first hsync-low clock.
    task automatic test_async_reset();
        repeat (20) @(negedge clk);
        checks++;
        if (hsync !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prereset_state: got hsync=%b running=%b expected 0 1", hsync, running);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_vec !== IDLE) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", out_vec, IDLE);
        end
        @(negedge clk);
        test_startup();
    endtask

    // Default instance restarted alongside the scaled one: now at h=0, v=0.
    task automatic test_default_line();
        int de_cnt   = 0;
        int hs_cnt   = 0;
        int hs_first = -1;
        for (int i = 0; i < 800; i++) begin
            if (d_de) de_cnt++;
            if (!d_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            @(negedge clk);
        end
        checks++;
        if (de_cnt != 640) begin
            errors++;
            $display("[TB] FAIL default_de_count: got %0d expected 640", de_cnt);
        end
        checks++;
        if (hs_cnt != 96 || hs_first != 656) begin
            errors++;
            $display("[TB] FAIL default_hsync: got width=%0d start=%0d expected 96 656", hs_cnt, hs_first);
        end
        checks++;
        if ({d_line_start, d_de, d_pix_x, d_pix_y} !== {1'b1, 1'b1, 10'd0, 10'd1}) begin
            errors++;
            $display("[TB] FAIL default_line_period: got ls=%b de=%b x=%0d y=%0d expected 1 1 0 1",
                     d_line_start, d_de, d_pix_x, d_pix_y);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_startup();
        test_line();
        test_frame();
        test_last_pixel();
        test_lock_loss();
        test_async_reset();
        test_default_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
